lcd_byte_writer: RTL and testbench
==================================

Name: lcd_byte_writer

Overview:
- Downstream output stage for the mini ALU. It consumes bytes the ALU emits, either display data or LCD commands, through a valid/ready handshake.
- It drives an HD44780-class character LCD over its 4-bit interface: power-up init sequence, nibble splitting, E-strobe timing and post-command busy wait.
- It replaces the direct LED register as the ALU's human-visible output path.

Parameters:
- SETUP_CYCLES, 3: cycles RS/data are stable before E rises.
- PULSE_CYCLES, 12: cycles E is held high.
- HOLD_CYCLES, 1: cycles RS/data are held after E falls.
- GAP_CYCLES, 50: cycles between the high-nibble hold end and the low-nibble setup start.
- WAIT_CYCLES, 2000: post-byte wait for normal commands and data.
- LONG_WAIT_CYCLES, 82000: post-byte wait for Clear (0x01) and Home (0x02/0x03) with RS=0.
- POWERUP_CYCLES, 750000: idle delay after reset before the first init nibble.
- INIT_WAIT1_CYCLES, 205000: wait after the first init nibble.
- INIT_WAIT2_CYCLES, 5000: wait after the second init nibble.

Ports:
- Clock, input, 1: single clock; all state on the rising edge.
- Reset, input, 1: asynchronous, active-high.
- iData, input, 8: byte to write.
- iRS, input, 1: 0 = command, 1 = data.
- iValid, input, 1: iData/iRS valid.
- oReady, output, 1: block can accept a byte.
- oLCD_Data, output, 4: LCD DB7..DB4.
- oLCD_RS, output, 1: LCD register select.
- oLCD_RW, output, 1: tied 0 (write only).
- oLCD_E, output, 1: LCD enable strobe.

Behaviour:
- Reset is asynchronous and active-high. While Reset is high, all outputs are 0 and the state is PWR_WAIT with the counter cleared.
- A reset asserted mid-operation forces oLCD_E low immediately, drops any in-flight byte, and restarts the full init sequence.
- States: PWR_WAIT, INIT_NIB, INIT_WAIT, IDLE, HI_SETUP, HI_PULSE, HI_HOLD, GAP, LO_SETUP, LO_PULSE, LO_HOLD, BUSY_WAIT.
- One down-counter is shared by all states. Each state lasts exactly its parameter count of cycles.
- Nibble strobe:
  - oLCD_RS and oLCD_Data are set on entry to SETUP.
  - oLCD_E is 1 only during PULSE.
  - oLCD_RS and oLCD_Data are unchanged through HOLD.
  - E never rises in the same cycle that data or RS changes.
- Init sequence (RS=0), each nibble using the strobe then a wait:
  - 0x3, then INIT_WAIT1_CYCLES.
  - 0x3, then INIT_WAIT2_CYCLES.
  - 0x3, then WAIT_CYCLES.
  - 0x2, then WAIT_CYCLES.
  - Then go to IDLE.
- oReady is 1 only in IDLE, and it is registered.
- A transfer happens when iValid && oReady are both 1 at a clock edge. On that edge:
  - iData and iRS are captured into internal registers.
  - The state moves to HI_SETUP and oReady goes to 0.
  - iValid and iData are don't-care from then until oReady returns.
- Byte sequence: HI_* drives iData[7:4], then GAP, then LO_* drives iData[3:0], then BUSY_WAIT.
  - BUSY_WAIT lasts LONG_WAIT_CYCLES when RS=0 and data is 0x01, 0x02 or 0x03; otherwise WAIT_CYCLES.
- Accept-to-ready latency is 2*(SETUP+PULSE+HOLD) + GAP + wait cycles. oReady is high again on the edge ending BUSY_WAIT.
- Back-to-back traffic: iValid held high with a new byte is accepted on the first IDLE cycle. The minimum IDLE dwell is one cycle.
- iValid asserted during init or busy is ignored (not queued). The producer holds it until oReady is seen.
- oLCD_Data is 0 in IDLE, PWR_WAIT and every wait state. oLCD_RS holds its last value until the next SETUP.
- Any parameter set to 0 is treated as 1.
- The counter is 20 bits and must hold LONG_WAIT_CYCLES and POWERUP_CYCLES.

Decomposition:
- Shared header file (same style as the ALU opcode definitions) holds:
  - state encodings (4-bit);
  - LCD command constants: CLEAR=0x01, HOME=0x02, FUNCSET_4BIT=0x28, ENTRY=0x06, DISPLAY_ON=0x0C;
  - default timing constants for the 50 MHz board.
- One sub-module, lcd_nibble_strobe: given start, nibble and RS, it produces the SETUP/PULSE/HOLD sequence and a done pulse.
  - Reused by both the init path and the byte path.

Test Plan (SETUP=2, PULSE=4, HOLD=2, GAP=3, WAIT=10, LONG_WAIT=50, POWERUP=20, INIT_WAIT1=15, INIT_WAIT2=5):
- Release reset: four E pulses, each 4 cycles wide, with data 3,3,3,2, RS=0. oReady rises exactly 92 cycles after the first edge following reset release; no E pulse occurs during the first 20 cycles.
- Accept iData=0x41 with RS=1: E pulse 1 carries data 0x4 and pulse 2 carries 0x1, RS=1 throughout. The gap from the first E fall to the second E rise is 2+3+2=7 cycles. oReady returns 29 cycles after the accept edge.
- Accept command 0x01 with RS=0: oReady returns 69 cycles after accept. Command 0x28 returns in 29 cycles.
- Hold iValid high with 0x48, 0x49 back-to-back: each byte is accepted only on an oReady=1 edge, never twice. Second accept occurs at the 30th cycle after the first.
- Assert Reset during the LO_PULSE of a byte: oLCD_E goes to 0 in the same cycle without waiting for a clock, oReady=0, and the full 92-cycle init reruns after release.
- Assertion checks, always on:
  - oLCD_RW == 0;
  - oLCD_Data and oLCD_RS are stable whenever oLCD_E == 1;
  - every E high pulse is exactly PULSE_CYCLES long.

Source files
------------

// File: rtl/lcd_byte_writer_pkg.sv
// lcd_byte_writer_pkg: state encodings, LCD command codes and default 50 MHz timing for the LCD writer.
package lcd_byte_writer_pkg;

    localparam int CNT_W = 20;

    typedef enum logic [3:0] {
        PWR_WAIT  = 4'd0,
        INIT_NIB  = 4'd1,
        INIT_WAIT = 4'd2,
        IDLE      = 4'd3,
        HI_SETUP  = 4'd4,
        HI_PULSE  = 4'd5,
        HI_HOLD   = 4'd6,
        GAP       = 4'd7,
        LO_SETUP  = 4'd8,
        LO_PULSE  = 4'd9,
        LO_HOLD   = 4'd10,
        BUSY_WAIT = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_SETUP = 2'd1,
        PH_PULSE = 2'd2,
        PH_HOLD  = 2'd3
    } phase_e;

    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_HOME         = 8'h02;
    localparam logic [7:0] CMD_FUNCSET_4BIT = 8'h28;
    localparam logic [7:0] CMD_ENTRY        = 8'h06;
    localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;

    localparam int DEF_SETUP_CYCLES      = 3;
    localparam int DEF_PULSE_CYCLES      = 12;
    localparam int DEF_HOLD_CYCLES       = 1;
    localparam int DEF_GAP_CYCLES        = 50;
    localparam int DEF_WAIT_CYCLES       = 2000;
    localparam int DEF_LONG_WAIT_CYCLES  = 82000;
    localparam int DEF_POWERUP_CYCLES    = 750000;
    localparam int DEF_INIT_WAIT1_CYCLES = 205000;
    localparam int DEF_INIT_WAIT2_CYCLES = 5000;

    // A zero-length phase would never let the down-counter terminate, so it is stretched to one cycle.
    function automatic logic [CNT_W-1:0] cyc_len(input int n);
        return (n < 1) ? CNT_W'(1) : CNT_W'(n);
    endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// lcd_nibble_strobe: one SETUP/PULSE/HOLD E-strobe for a 4-bit LCD nibble.
// Phase lengths come from the owner's shared down-counter via tc_i.
module lcd_nibble_strobe
    import lcd_byte_writer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       tc_i,
    input  logic [3:0] nib_i,
    input  logic       rs_i,
    output logic [1:0] ph_o,
    output logic       done_o,
    output logic [3:0] data_o,
    output logic       rs_o,
    output logic       e_o
);

    phase_e     ph_q;
    logic [3:0] data_q;
    logic       rs_q;
    logic       e_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_q   <= PH_IDLE;
            data_q <= '0;
            rs_q   <= 1'b0;
            e_q    <= 1'b0;
        end else if (start_i) begin
            ph_q   <= PH_SETUP;
            data_q <= nib_i;
            rs_q   <= rs_i;
            e_q    <= 1'b0;
        end else if (tc_i) begin
            case (ph_q)
                PH_SETUP: begin
                    ph_q <= PH_PULSE;
                    e_q  <= 1'b1;
                end
                PH_PULSE: begin
                    ph_q <= PH_HOLD;
                    e_q  <= 1'b0;
                end
                PH_HOLD: begin
                    ph_q   <= PH_IDLE;
                    data_q <= '0;
                end
                default: ph_q <= PH_IDLE;
            endcase
        end
    end

    assign ph_o   = ph_q;
    assign done_o = (ph_q == PH_HOLD) && tc_i;
    assign data_o = data_q;
    assign rs_o   = rs_q;
    assign e_o    = e_q;

endmodule

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: accepts command/data bytes over valid/ready and writes them to an HD44780 LCD
// in 4-bit mode, running the power-up init sequence first.
module lcd_byte_writer
    import lcd_byte_writer_pkg::*;
#(
    parameter int SETUP_CYCLES      = DEF_SETUP_CYCLES,
    parameter int PULSE_CYCLES      = DEF_PULSE_CYCLES,
    parameter int HOLD_CYCLES       = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES        = DEF_GAP_CYCLES,
    parameter int WAIT_CYCLES       = DEF_WAIT_CYCLES,
    parameter int LONG_WAIT_CYCLES  = DEF_LONG_WAIT_CYCLES,
    parameter int POWERUP_CYCLES    = DEF_POWERUP_CYCLES,
    parameter int INIT_WAIT1_CYCLES = DEF_INIT_WAIT1_CYCLES,
    parameter int INIT_WAIT2_CYCLES = DEF_INIT_WAIT2_CYCLES
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic [3:0] oLCD_Data,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic       oLCD_E
);

    localparam logic [CNT_W-1:0] L_SETUP   = cyc_len(SETUP_CYCLES);
    localparam logic [CNT_W-1:0] L_PULSE   = cyc_len(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] L_HOLD    = cyc_len(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] L_GAP     = cyc_len(GAP_CYCLES);
    localparam logic [CNT_W-1:0] L_WAIT    = cyc_len(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] L_LONG    = cyc_len(LONG_WAIT_CYCLES);
    localparam logic [CNT_W-1:0] L_POWERUP = cyc_len(POWERUP_CYCLES);
    localparam logic [CNT_W-1:0] L_W1      = cyc_len(INIT_WAIT1_CYCLES);
    localparam logic [CNT_W-1:0] L_W2      = cyc_len(INIT_WAIT2_CYCLES);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic [7:0]       byte_q;
    logic             rs_q;
    logic             ready_q;

    logic             tc;
    logic             start;
    logic [3:0]       nib_d;
    logic             rs_d;
    logic             long_wait;
    logic [CNT_W-1:0] init_wait;
    logic [1:0]       ph;
    logic             done;

    always_comb begin
        tc        = cnt_q == CNT_W'(1);
        start     = (state_q == PWR_WAIT && tc) || (state_q == INIT_WAIT && tc && idx_q != 2'd3) ||
                    (state_q == IDLE && iValid && ready_q) || (state_q == GAP && tc);
        nib_d     = (state_q == IDLE) ? iData[7:4] : (state_q == GAP) ? byte_q[3:0] :
                    (idx_q == 2'd2) ? 4'h2 : 4'h3;
        rs_d      = (state_q == IDLE) ? iRS : (state_q == GAP) ? rs_q : 1'b0;
        long_wait = !rs_q && (byte_q == CMD_CLEAR || byte_q[7:1] == CMD_HOME[7:1]);
        init_wait = (idx_q == 2'd0) ? L_W1 : (idx_q == 2'd1) ? L_W2 : L_WAIT;
    end

    // Counter holds remaining cycles of the current state; cleared only by reset, which PWR_WAIT uses to arm itself.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= PWR_WAIT;
            cnt_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            rs_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            case (state_q)
                PWR_WAIT: begin
                    if (cnt_q == '0) cnt_q <= L_POWERUP;
                    else if (tc) begin
                        state_q <= INIT_NIB;
                        cnt_q   <= L_SETUP;
                    end
                end
                INIT_NIB: begin
                    if (done) begin
                        state_q <= INIT_WAIT;
                        cnt_q   <= init_wait;
                    end else if (tc) cnt_q <= (ph == PH_SETUP) ? L_PULSE : L_HOLD;
                end
                INIT_WAIT: begin
                    if (tc && idx_q == 2'd3) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else if (tc) begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= INIT_NIB;
                        cnt_q   <= L_SETUP;
                    end
                end
                IDLE: begin
                    if (iValid && ready_q) begin
                        byte_q  <= iData;
                        rs_q    <= iRS;
                        ready_q <= 1'b0;
                        state_q <= HI_SETUP;
                        cnt_q   <= L_SETUP;
                    end
                end
                HI_SETUP: begin
                    if (tc) begin
                        state_q <= HI_PULSE;
                        cnt_q   <= L_PULSE;
                    end
                end
                HI_PULSE: begin
                    if (tc) begin
                        state_q <= HI_HOLD;
                        cnt_q   <= L_HOLD;
                    end
                end
                HI_HOLD: begin
                    if (done) begin
                        state_q <= GAP;
                        cnt_q   <= L_GAP;
                    end
                end
                GAP: begin
                    if (tc) begin
                        state_q <= LO_SETUP;
                        cnt_q   <= L_SETUP;
                    end
                end
                LO_SETUP: begin
                    if (tc) begin
                        state_q <= LO_PULSE;
                        cnt_q   <= L_PULSE;
                    end
                end
                LO_PULSE: begin
                    if (tc) begin
                        state_q <= LO_HOLD;
                        cnt_q   <= L_HOLD;
                    end
                end
                LO_HOLD: begin
                    if (done) begin
                        state_q <= BUSY_WAIT;
                        cnt_q   <= long_wait ? L_LONG : L_WAIT;
                    end
                end
                BUSY_WAIT: begin
                    if (tc) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= PWR_WAIT;
            endcase
        end
    end

    lcd_nibble_strobe u_strobe (
        .clk    (Clock),
        .rst    (Reset),
        .start_i(start),
        .tc_i   (tc),
        .nib_i  (nib_d),
        .rs_i   (rs_d),
        .ph_o   (ph),
        .done_o (done),
        .data_o (oLCD_Data),
        .rs_o   (oLCD_RS),
        .e_o    (oLCD_E)
    );

    assign oReady  = ready_q;
    assign oLCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// tb_lcd_byte_writer: scoreboard bench for lcd_byte_writer with small timing parameters.
module tb_lcd_byte_writer;

    localparam int SU = 2, PU = 4, HO = 2, GA = 3, WT = 10, LW = 50, PW = 20, W1 = 15, W2 = 5;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] iData = 8'h00;
    logic       iRS = 1'b0;
    logic       iValid = 1'b0;
    logic       oReady;
    logic [3:0] oLCD_Data;
    logic       oLCD_RS;
    logic       oLCD_RW;
    logic       oLCD_E;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    typedef struct {
        logic       rs;
        logic [3:0] nib;
        int         t;
    } nib_t;

    nib_t exp_nib[$];
    int   exp_rdy[$];

    lcd_byte_writer #(
        .SETUP_CYCLES(SU), .PULSE_CYCLES(PU), .HOLD_CYCLES(HO), .GAP_CYCLES(GA),
        .WAIT_CYCLES(WT), .LONG_WAIT_CYCLES(LW), .POWERUP_CYCLES(PW),
        .INIT_WAIT1_CYCLES(W1), .INIT_WAIT2_CYCLES(W2)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iData(iData), .iRS(iRS), .iValid(iValid),
        .oReady(oReady), .oLCD_Data(oLCD_Data), .oLCD_RS(oLCD_RS), .oLCD_RW(oLCD_RW), .oLCD_E(oLCD_E)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops an expected nibble on every E rise and an expected cycle on every oReady rise.
    initial begin : monitor
        logic       e_prev = 1'b0;
        logic       r_prev = 1'b0;
        logic [4:0] held = '0;
        int         wid = 0;
        nib_t       x;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                e_prev = 1'b0;
                r_prev = 1'b0;
                wid = 0;
            end else begin
                check("rw_low", oLCD_RW, 0);
                if (oLCD_E && !e_prev) begin
                    check("pulse_expected", exp_nib.size() > 0, 1);
                    if (exp_nib.size() > 0) begin
                        x = exp_nib.pop_front();
                        check("nibble", oLCD_Data, x.nib);
                        check("rs", oLCD_RS, x.rs);
                        check("e_rise_cycle", cyc, x.t);
                    end
                    held = {oLCD_RS, oLCD_Data};
                    wid = 1;
                end else if (oLCD_E) begin
                    wid++;
                    check("stable_while_e", {oLCD_RS, oLCD_Data}, held);
                end else if (e_prev) begin
                    check("pulse_width", wid, PU);
                end
                if (oReady && !r_prev) begin
                    check("ready_expected", exp_rdy.size() > 0, 1);
                    if (exp_rdy.size() > 0) check("ready_cycle", cyc, exp_rdy.pop_front());
                end
                e_prev = oLCD_E;
                r_prev = oReady;
            end
        end
    end

    task automatic release_init();
        int c1;
        @(negedge Clock);
        Reset = 1'b0;
        c1 = cyc + 1;
        exp_nib.push_back(nib_t'{1'b0, 4'h3, c1 + 22});
        exp_nib.push_back(nib_t'{1'b0, 4'h3, c1 + 45});
        exp_nib.push_back(nib_t'{1'b0, 4'h3, c1 + 58});
        exp_nib.push_back(nib_t'{1'b0, 4'h2, c1 + 76});
        exp_rdy.push_back(c1 + 92);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((exp_nib.size() != 0 || exp_rdy.size() != 0) && n < bound) begin
            @(negedge Clock);
            n++;
        end
        check("drain_left", exp_nib.size() + exp_rdy.size(), 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge Clock);
        while (!oReady && n < 200) begin
            @(negedge Clock);
            n++;
        end
        check("ready_timeout", oReady, 1);
    endtask

    task automatic send(input logic [7:0] d, input logic rs, input int lat);
        int a;
        wait_ready();
        a = cyc + 1;
        exp_nib.push_back(nib_t'{rs, d[7:4], a + 2});
        exp_nib.push_back(nib_t'{rs, d[3:0], a + 13});
        exp_rdy.push_back(a + lat);
        iData = d;
        iRS = rs;
        iValid = 1'b1;
        @(negedge Clock);
        iValid = 1'b0;
        iData = 8'($urandom);
        iRS = 1'($urandom);
    endtask

    initial begin : stim
        int a;
        int n;
        #1;
        check("rst_ready", oReady, 0);
        check("rst_e", oLCD_E, 0);
        check("rst_data", oLCD_Data, 0);
        check("rst_rs", oLCD_RS, 0);
        repeat (3) @(negedge Clock);
        release_init();
        wait_drain(300);

        send(8'h41, 1'b1, 29);
        send(8'h01, 1'b0, 69);
        send(8'h28, 1'b0, 29);
        send(8'h03, 1'b0, 69);
        send(8'h01, 1'b1, 29);
        send(8'h02, 1'b0, 69);
        send(8'h04, 1'b0, 29);
        wait_drain(200);

        // Back-to-back: iValid held high across two bytes.
        wait_ready();
        a = cyc + 1;
        exp_nib.push_back(nib_t'{1'b1, 4'h4, a + 2});
        exp_nib.push_back(nib_t'{1'b1, 4'h8, a + 13});
        exp_rdy.push_back(a + 29);
        exp_nib.push_back(nib_t'{1'b1, 4'h4, a + 32});
        exp_nib.push_back(nib_t'{1'b1, 4'h9, a + 43});
        exp_rdy.push_back(a + 59);
        iData = 8'h48;
        iRS = 1'b1;
        iValid = 1'b1;
        @(negedge Clock);
        check("b2b_first_taken", oReady, 0);
        iData = 8'h49;
        n = 0;
        while (!oReady && n < 100) begin
            @(negedge Clock);
            n++;
        end
        @(negedge Clock);
        check("b2b_second_accept_cycle", cyc, a + 30);
        check("b2b_second_taken", oReady, 0);
        iValid = 1'b0;
        wait_drain(200);

        // Reset during the low-nibble pulse.
        wait_ready();
        a = cyc + 1;
        exp_nib.push_back(nib_t'{1'b1, 4'h5, a + 2});
        exp_nib.push_back(nib_t'{1'b1, 4'hA, a + 13});
        iData = 8'h5A;
        iRS = 1'b1;
        iValid = 1'b1;
        @(negedge Clock);
        iValid = 1'b0;
        n = 0;
        while (cyc < a + 14 && n < 100) begin
            @(negedge Clock);
            n++;
        end
        check("pre_reset_e", oLCD_E, 1);
        check("pre_reset_queue", exp_nib.size(), 0);
        @(posedge Clock);
        #2;
        Reset = 1'b1;
        #1;
        check("midrst_e", oLCD_E, 0);
        check("midrst_ready", oReady, 0);
        check("midrst_data", oLCD_Data, 0);
        check("midrst_rs", oLCD_RS, 0);
        repeat (2) @(negedge Clock);
        release_init();
        wait_drain(300);
        send(8'h0C, 1'b0, 29);
        wait_drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", compared, mismatched);
        $fatal(1);
    end

endmodule
